// File: rtl/bp_pkg.sv
// Shared types and helpers for the bimodal branch predictor.
//   PC_W        : architectural PC width.
//   CNT_*       : 2-bit saturating counter encodings (strong/weak, taken/not-taken).
//   bp_entry_t  : one predictor entry {valid, tag, target, cnt}. The tag field is sized for
//                 the smallest legal index (TAG_MAX_W); bits above the active tag width are
//                 always written as zero.
//   sat_update  : saturating +1 on taken, -1 on not-taken.
package bp_pkg;

  localparam int unsigned PC_W      = 32;
  localparam int unsigned TAG_MAX_W = PC_W - 2;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [PC_W-1:0]      target;
    logic [1:0]           cnt;
  } bp_entry_t;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    res = cnt;
    if (taken) begin
      if (cnt != CNT_ST) res = cnt + 2'b01;
    end else begin
      if (cnt != CNT_SNT) res = cnt - 2'b01;
    end
    return res;
  endfunction

endpackage

// File: rtl/bp_table.sv
// Predictor entry storage: 2**IDX_W entries of bp_entry_t.
//   clk_i, nreset_i : clock and synchronous active-low clear (valid=0, cnt=weak not-taken).
//   rd_en_i/rd_idx_i/rd_entry_o : synchronous read port; data appears after the edge and
//                                 holds while rd_en_i is low.
//   wr_idx_i/wr_cur_o           : current contents at the write index for read-modify-write.
//   wr_en_i/wr_entry_i          : synchronous write port.
// A read and write to the same index in one cycle returns the pre-write entry.
module bp_table
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk_i,
  input  logic             nreset_i,
  input  logic             rd_en_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output bp_entry_t        rd_entry_o,
  input  logic [IDX_W-1:0] wr_idx_i,
  output bp_entry_t        wr_cur_o,
  input  logic             wr_en_i,
  input  bp_entry_t        wr_entry_i
);

  localparam int unsigned Entries = 2 ** IDX_W;
  localparam bp_entry_t ResetEntry = '{valid: 1'b0, tag: '0, target: '0, cnt: CNT_WNT};

  bp_entry_t mem_q [Entries];
  bp_entry_t rd_q;

  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      for (int i = 0; i < Entries; i++) mem_q[i] <= ResetEntry;
      rd_q <= ResetEntry;
    end else begin
      if (rd_en_i) rd_q <= mem_q[rd_idx_i];
      if (wr_en_i) mem_q[wr_idx_i] <= wr_entry_i;
    end
  end

  assign rd_entry_o = rd_q;
  assign wr_cur_o   = mem_q[wr_idx_i];

endmodule

// File: rtl/branch_pred.sv
// Fetch-stage bimodal branch predictor with a direct-mapped BTB.
//   clk_i, nreset_i   : clock and synchronous active-low reset (highest priority).
//   ena_i             : pipeline advance; low stalls outputs and blocks table writes.
//   fetch_req_i/pc_i  : lookup request; prediction appears one cycle later.
//   pred_valid_o      : pred_* refer to the previous accepted fetch request.
//   pred_taken_o      : hit and counter MSB set.
//   pred_target_o     : predicted target (bit 0 clear), zero when not taken.
//   upd_*_i           : resolved conditional branch outcome from execute.
module branch_pred
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W    = 4,
  parameter logic [1:0]  INIT_CNT = CNT_WT
) (
  input  logic            clk_i,
  input  logic            nreset_i,
  input  logic            ena_i,
  input  logic            fetch_req_i,
  input  logic [PC_W-1:0] fetch_pc_i,
  output logic            pred_valid_o,
  output logic            pred_taken_o,
  output logic [PC_W-1:0] pred_target_o,
  input  logic            upd_valid_i,
  input  logic [PC_W-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [PC_W-1:0] upd_target_i
);

  localparam int unsigned TAG_W = PC_W - IDX_W - 2;

  typedef logic [TAG_MAX_W-1:0] tag_t;

  // Tag zero-extended to the entry's tag field width.
  function automatic tag_t tag_of(input logic [PC_W-1:0] pc);
    tag_t t;
    t = '0;
    t[TAG_W-1:0] = pc[PC_W-1:IDX_W+2];
    return t;
  endfunction

  logic [IDX_W-1:0] fetch_idx, upd_idx;
  tag_t             fetch_tag, upd_tag;
  logic [PC_W-1:0]  upd_target_clr;

  assign fetch_idx      = fetch_pc_i[IDX_W+1:2];
  assign upd_idx        = upd_pc_i[IDX_W+1:2];
  assign fetch_tag      = tag_of(fetch_pc_i);
  assign upd_tag        = tag_of(upd_pc_i);
  assign upd_target_clr = {upd_target_i[PC_W-1:1], 1'b0};

  logic      rd_en;
  bp_entry_t rd_entry, wr_cur, wr_entry;
  logic      wr_en;
  logic      upd_hit;

  assign rd_en = ena_i & fetch_req_i;

  bp_table #(
    .IDX_W (IDX_W)
  ) u_table (
    .clk_i      (clk_i),
    .nreset_i   (nreset_i),
    .rd_en_i    (rd_en),
    .rd_idx_i   (fetch_idx),
    .rd_entry_o (rd_entry),
    .wr_idx_i   (upd_idx),
    .wr_cur_o   (wr_cur),
    .wr_en_i    (wr_en),
    .wr_entry_i (wr_entry)
  );

  // Update policy: train on hit, allocate only on a taken miss.
  always_comb begin
    wr_en    = 1'b0;
    wr_entry = wr_cur;
    upd_hit  = wr_cur.valid && (wr_cur.tag == upd_tag);
    if (ena_i && upd_valid_i) begin
      if (upd_hit) begin
        wr_en        = 1'b1;
        wr_entry.cnt = sat_update(wr_cur.cnt, upd_taken_i);
        if (upd_taken_i) wr_entry.target = upd_target_clr;
      end else if (upd_taken_i) begin
        wr_en    = 1'b1;
        wr_entry = '{valid: 1'b1, tag: upd_tag, target: upd_target_clr, cnt: INIT_CNT};
      end
    end
  end

  logic pred_valid_q, pred_valid_d;
  tag_t fetch_tag_q, fetch_tag_d;

  always_comb begin
    pred_valid_d = pred_valid_q;
    fetch_tag_d  = fetch_tag_q;
    if (ena_i) begin
      pred_valid_d = fetch_req_i;
      if (fetch_req_i) fetch_tag_d = fetch_tag;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      pred_valid_q <= 1'b0;
      fetch_tag_q  <= '0;
    end else begin
      pred_valid_q <= pred_valid_d;
      fetch_tag_q  <= fetch_tag_d;
    end
  end

  // The read register and captured tag both hold during a stall, so the
  // prediction derived from them holds as well.
  logic lookup_hit;
  assign lookup_hit    = rd_entry.valid && (rd_entry.tag == fetch_tag_q);
  assign pred_valid_o  = pred_valid_q;
  assign pred_taken_o  = pred_valid_q & lookup_hit & rd_entry.cnt[1];
  assign pred_target_o = pred_taken_o ? rd_entry.target : '0;

  logic unused_bits;
  assign unused_bits = ^{fetch_pc_i[1:0], upd_pc_i[1:0], upd_target_i[0], rd_entry.cnt[0]};

endmodule

// File: tb/tb_branch_pred.sv
module tb_branch_pred;

  logic        clk = 1'b0;
  logic        nreset, ena, fetch_req, upd_valid, upd_taken;
  logic [31:0] fetch_pc, upd_pc, upd_target;
  logic        pred_valid, pred_taken;
  logic [31:0] pred_target;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_pred dut (
    .clk_i         (clk),
    .nreset_i      (nreset),
    .ena_i         (ena),
    .fetch_req_i   (fetch_req),
    .fetch_pc_i    (fetch_pc),
    .pred_valid_o  (pred_valid),
    .pred_taken_o  (pred_taken),
    .pred_target_o (pred_target),
    .upd_valid_i   (upd_valid),
    .upd_pc_i      (upd_pc),
    .upd_taken_i   (upd_taken),
    .upd_target_i  (upd_target)
  );

  // Reference model: table of entries indexed by pc[5:2], tagged by pc[31:6].
  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_cnt   [16];
  logic        e_valid = 1'b0, e_taken = 1'b0;
  logic [31:0] e_target = '0;

  // Apply the model for the upcoming edge, then advance one clock and settle.
  task automatic step();
    int unsigned fi, ft, ui, ut;
    bit hit;
    fi = (fetch_pc >> 2) & 15; ft = fetch_pc >> 6;
    ui = (upd_pc >> 2) & 15;   ut = upd_pc >> 6;
    if (!nreset) begin
      for (int i = 0; i < 16; i++) begin m_valid[i] = 0; m_cnt[i] = 1; end
      e_valid = 0; e_taken = 0; e_target = 0;
    end else if (ena) begin
      if (fetch_req) begin
        hit = m_valid[fi] && m_tag[fi] == ft;
        e_valid = 1;
        e_taken = hit && m_cnt[fi] >= 2;
        e_target = e_taken ? (m_tgt[fi] & 32'hFFFF_FFFE) : 32'h0;
      end else begin
        e_valid = 0; e_taken = 0; e_target = 0;
      end
      if (upd_valid) begin
        hit = m_valid[ui] && m_tag[ui] == ut;
        if (hit) begin
          if (upd_taken) begin
            m_cnt[ui] = (m_cnt[ui] == 3) ? 3 : m_cnt[ui] + 1;
            m_tgt[ui] = upd_target;
          end else begin
            m_cnt[ui] = (m_cnt[ui] == 0) ? 0 : m_cnt[ui] - 1;
          end
        end else if (upd_taken) begin
          m_valid[ui] = 1; m_tag[ui] = ut; m_tgt[ui] = upd_target; m_cnt[ui] = 2;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    nreset = 1; ena = 1; fetch_req = 0; upd_valid = 0; upd_taken = 0;
    fetch_pc = 0; upd_pc = 0; upd_target = 0;
  endtask

  task automatic do_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    upd_valid = 1; upd_pc = pc; upd_taken = tk; upd_target = tgt; fetch_req = 0;
    step();
    upd_valid = 0;
  endtask

  task automatic do_fetch(input logic [31:0] pc);
    fetch_req = 1; fetch_pc = pc;
    step();
    fetch_req = 0;
  endtask

  task automatic do_reset();
    nreset = 0; step(); nreset = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    checks++;
    if (pred_valid !== 1'b0 || pred_taken !== 1'b0 || pred_target !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b t=%b tgt=%h, want 0 0 0",
               pred_valid, pred_taken, pred_target);
    end
    do_fetch(32'h100);
    checks++;
    if (pred_valid !== 1'b1 || pred_taken !== 1'b0 || pred_target !== 32'h0) begin
      failures++;
      $display("FAIL cold_lookup: got v=%b t=%b tgt=%h, want 1 0 0",
               pred_valid, pred_taken, pred_target);
    end
    step();
    checks++;
    if (pred_valid !== 1'b0) begin
      failures++;
      $display("FAIL no_req_clears_valid: got %b want 0", pred_valid);
    end
  endtask

  task automatic test_alloc_hit();
    do_update(32'h100, 1, 32'h200);
    do_fetch(32'h100);
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin
      failures++;
      $display("FAIL alloc_hit: got t=%b tgt=%h, want 1 00000200", pred_taken, pred_target);
    end
  endtask

  task automatic test_hysteresis();
    do_update(32'h100, 0, 32'h0);
    do_fetch(32'h100);
    checks++;
    if (pred_taken !== 1'b0) begin
      failures++; $display("FAIL hyst_one_nt: got %b want 0", pred_taken);
    end
    do_update(32'h100, 1, 32'h200);
    do_fetch(32'h100);
    checks++;
    if (pred_taken !== 1'b1) begin
      failures++; $display("FAIL hyst_back_t: got %b want 1", pred_taken);
    end
    repeat (3) do_update(32'h100, 1, 32'h200);
    do_update(32'h100, 0, 32'h0);
    do_fetch(32'h100);
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin
      failures++;
      $display("FAIL hyst_strong: got t=%b tgt=%h, want 1 00000200", pred_taken, pred_target);
    end
  endtask

  task automatic test_alias();
    do_fetch(32'h140);
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin
      failures++;
      $display("FAIL alias_miss: got t=%b tgt=%h, want 0 0", pred_taken, pred_target);
    end
    do_update(32'h140, 1, 32'h300);
    do_fetch(32'h140);
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h300) begin
      failures++;
      $display("FAIL alias_alloc: got t=%b tgt=%h, want 1 00000300", pred_taken, pred_target);
    end
    do_fetch(32'h100);
    checks++;
    if (pred_taken !== 1'b0) begin
      failures++; $display("FAIL alias_evicted: got %b want 0", pred_taken);
    end
  endtask

  task automatic test_collision();
    do_reset();
    do_update(32'h100, 1, 32'h200);
    fetch_req = 1; fetch_pc = 32'h100;
    upd_valid = 1; upd_pc = 32'h100; upd_taken = 0; upd_target = 0;
    step();
    fetch_req = 0; upd_valid = 0;
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin
      failures++;
      $display("FAIL rbw_same_cycle: got t=%b tgt=%h, want 1 00000200", pred_taken, pred_target);
    end
    do_fetch(32'h100);
    checks++;
    if (pred_taken !== 1'b0) begin
      failures++; $display("FAIL rbw_next: got %b want 0", pred_taken);
    end
  endtask

  task automatic test_stall();
    do_update(32'h100, 1, 32'h200);
    do_fetch(32'h100);
    ena = 0; fetch_req = 1; fetch_pc = 32'h140;
    for (int i = 0; i < 3; i++) begin
      upd_valid = (i != 1); upd_pc = 32'h100; upd_taken = 0;
      step();
      checks++;
      if (pred_valid !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h200) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got v=%b t=%b tgt=%h, want 1 1 00000200",
                 i, pred_valid, pred_taken, pred_target);
      end
    end
    ena = 1; upd_valid = 0; fetch_req = 0;
    do_fetch(32'h100);
    checks++;
    if (pred_taken !== 1'b1) begin
      failures++; $display("FAIL stall_no_write: got %b want 1", pred_taken);
    end
  endtask

  task automatic test_mid_reset();
    do_fetch(32'h100);
    nreset = 0; fetch_req = 1; fetch_pc = 32'h100;
    upd_valid = 1; upd_pc = 32'h140; upd_taken = 1; upd_target = 32'h500;
    step();
    nreset = 1; fetch_req = 0; upd_valid = 0;
    checks++;
    if (pred_valid !== 1'b0 || pred_taken !== 1'b0 || pred_target !== 32'h0) begin
      failures++;
      $display("FAIL midreset_outputs: got v=%b t=%b tgt=%h, want 0 0 0",
               pred_valid, pred_taken, pred_target);
    end
    do_fetch(32'h100);
    checks++;
    if (pred_valid !== 1'b1 || pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL midreset_cleared: got v=%b t=%b, want 1 0", pred_valid, pred_taken);
    end
    do_fetch(32'h140);
    checks++;
    if (pred_taken !== 1'b0) begin
      failures++; $display("FAIL midreset_upd_dropped: got %b want 0", pred_taken);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      nreset    = ($urandom_range(0, 79) != 0);
      ena       = ($urandom_range(0, 7) != 0);
      fetch_req = $urandom_range(0, 1);
      fetch_pc  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2)
                | $urandom_range(0, 3);
      upd_valid = $urandom_range(0, 1);
      upd_pc    = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2)
                | $urandom_range(0, 3);
      upd_taken = ($urandom_range(0, 2) != 0);
      upd_target = $urandom;
      step();
      checks++;
      if (pred_valid !== e_valid || pred_taken !== e_taken || pred_target !== e_target) begin
        failures++;
        $display("FAIL random[%0d]: got v=%b t=%b tgt=%h, want v=%b t=%b tgt=%h",
                 n, pred_valid, pred_taken, pred_target, e_valid, e_taken, e_target);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_alloc_hit();
    test_hysteresis();
    test_alias();
    test_collision();
    test_stall();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_pred.md
Name: branch_pred

Overview:
- Fetch-stage branch predictor: bimodal table of 2-bit saturating counters plus a direct-mapped branch target buffer (BTB).
- Makes the taken/not-taken guess that travels down the pipe as flag bit 16 (predicted-taken) and steers fetch to the predicted target.
- Trains on the resolved outcome from the execute-stage jump control, which redirects the PC on a mismatch.
- It is the producer and consumer of the prediction the execute stage checks.

Parameters:
- IDX_W, 4, index bits; ENTRIES = 2**IDX_W.
- TAG_W, 26, tag bits = 32 - IDX_W - 2. Derived as a localparam, not user-set.
- INIT_CNT, 2'b10, counter value written on allocation (weak taken).

Ports:
- clk  in  1  clock, rising edge.
- nreset  in  1  synchronous reset, active low.
- ena  in  1  pipeline advance enable; low = stall.
- fetch_req  in  1  lookup request for fetch_pc this cycle.
- fetch_pc  in  32  PC being fetched; bits [1:0] ignored.
- pred_valid  out  1  pred_* outputs correspond to the previous accepted fetch_req.
- pred_taken  out  1  predicted taken; forwarded down the pipe as flags[16].
- pred_target  out  32  predicted target, bit 0 forced 0; equals 0 when pred_taken=0.
- upd_valid  in  1  resolved conditional branch from execute this cycle.
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  32  resolved target (rs1+imm, bit 0 cleared).

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]. The same split is used for lookup and update.
- Entry contents: valid(1), tag(TAG_W), target(32), cnt(2).
- Reset: nreset=0 at a clk edge does all of the following in one cycle and takes priority over everything else.
  - Clears all valid bits and sets all cnt to 2'b01.
  - Sets pred_valid=0, pred_taken=0, pred_target=0.
  - Applies mid-operation too: any in-flight lookup or update in that cycle is discarded.
- Lookup latency is 1 cycle.
  - If ena=1 and fetch_req=1 at edge N, then after edge N: pred_valid=1.
  - pred_taken = hit & cnt[1], where hit = valid & tag match.
  - pred_target = hit & cnt[1] ? target : 0.
- ena=1 with fetch_req=0: pred_valid goes to 0 and pred_taken to 0 at the next edge.
- ena=0 (stall): pred_* hold their values and the table is not written. An upd_valid arriving during a stall is dropped; execute does not assert it when ena=0.
- Update, applied at the edge when ena=1 and upd_valid=1:
  - Hit (valid & tag match at upd index):
    - cnt saturating +1 if upd_taken, -1 otherwise (11 and 00 saturate).
    - target overwritten with upd_target if upd_taken.
  - Miss and upd_taken=1: allocate valid=1, tag=upd tag, target=upd_target, cnt=INIT_CNT. This evicts the old entry.
  - Miss and upd_taken=0: no change.
- Same-cycle lookup and update to the same index is read-before-write. The lookup sees the pre-update entry; the new state is visible to the next lookup.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- No exceptions and no X propagation: an upd_pc/fetch_pc with bits [1:0]≠0 is treated as aligned.
- Unconditional jumps (flags[10]) are never sent as updates; they are never predicted.

Decomposition:
- Shared package bp_pkg holds:
  - constant PC_W=32;
  - counter encodings CNT_SNT/CNT_WNT/CNT_WT/CNT_ST;
  - entry typedef {valid, tag, target, cnt};
  - function sat_update(cnt, taken).
- One natural sub-module: bp_table, the register-file storage with a synchronous 1-read/1-write port, read-before-write, and sync clear. branch_pred holds index/tag split, hit logic, update policy and output registers.

Test Plan:
- Reset then lookup fetch_pc=0x100 with fetch_req=1 -> next cycle pred_valid=1, pred_taken=0, pred_target=0.
- Allocate and hit:
  - Stimulus: upd_valid, upd_pc=0x100, upd_taken=1, upd_target=0x200; then fetch 0x100.
  - Required: pred_taken=1, pred_target=0x200.
- Hysteresis, from allocated state (cnt=10) at 0x100:
  - 1 not-taken update -> fetch 0x100 gives pred_taken=0 (cnt=01).
  - 1 taken update -> pred_taken=1 again.
  - 3 taken updates -> cnt=11. Then 1 not-taken -> pred_taken still 1.
- Alias and tag mismatch (IDX_W=4):
  - Allocate 0x100; fetch 0x140 (same index, different tag) -> pred_taken=0.
  - Taken update at 0x140 target 0x300 -> 0x140 hits with 0x300; 0x100 now misses.
- Collisions:
  - Same-cycle fetch 0x100 and not-taken update 0x100 with cnt=10 -> that cycle's prediction is taken; the following fetch is not taken.
  - ena=0 for 3 cycles with upd_valid pulsed -> pred_* unchanged and table unchanged.
- Mid-operation reset: nreset=0 for 1 cycle after allocating 0x100 -> pred_valid=0 after the edge; a subsequent fetch 0x100 gives pred_taken=0.
